simple_bus_arbiter: RTL and testbench

SIMPLE_BUS_ARBITER -- requirements
Module: simple_bus_arbiter

---
 rtl/simple_bus_pkg.sv | 23 ++
 rtl/rr_picker.sv | 34 +++
 rtl/simple_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_simple_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple bus arbiter: transfer modes,
// FSM state encoding and default sizing.
package simple_bus_pkg;

  localparam int NREQ_DEFAULT    = 4;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    MODE_NOP   = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_GRANT = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int  NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PW:0]       sum;

  // Rotating a doubled copy puts the ptr slot at bit 0, so the search is a
  // plain lowest-set-bit scan; the offset is then added back modulo NREQ.
  always_comb begin
    dbl    = {req, req};
    rot    = dbl[ptr +: NREQ];
    sum    = '0;
    valid  = 1'b0;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum   = {1'b0, ptr} + (PW+1)'(k);
        valid = 1'b1;
      end
    end
    if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
    winner = sum[PW-1:0];
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ requesters, with a
// per-transfer wait timeout.
//
// state | meaning
// IDLE  | waiting for any req; latches winner and its addr/data/mode
// GRANT | gnt pulse to the winner
// START | mem_start pulse toward memory
// WAIT  | waiting for mem_rdy or timeout
// RESP  | done (and err on timeout) pulse; advance round-robin pointer
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ*2-1:0] req_mode,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              mem_start,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_data,
  output logic [1:0]        mem_mode,
  input  logic              mem_rdy,
  input  logic [7:0]        mem_rdata
);

  localparam int PW = $clog2(NREQ);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [7:0]      cnt;
  logic [PW-1:0]   pick_win;
  logic            pick_valid;
  logic [NREQ-1:0] win_oh;
  logic [7:0]      sel_addr;
  logic [7:0]      sel_data;
  logic [1:0]      sel_mode;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  assign win_oh = NREQ'(1) << win;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win == PW'(i)) begin
        sel_addr = req_addr[i*8 +: 8];
        sel_data = req_data[i*8 +: 8];
        sel_mode = req_mode[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      mem_start <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_mode  <= '0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      mem_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            win      <= pick_win;
            mem_addr <= sel_addr;
            mem_data <= sel_data;
            mem_mode <= sel_mode;
            gnt      <= NREQ'(1) << pick_win;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          mem_start <= 1'b1;
          state     <= ST_START;
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rdy) begin
            rd_data <= mem_rdata;
            done    <= win_oh;
            state   <= ST_RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            rd_data <= '0;
            done    <= win_oh;
            err     <= win_oh;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Bench for simple_bus_arbiter: transaction-timing model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_simple_bus_arbiter;
  import simple_bus_pkg::*;

  localparam int N  = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  req_mode = '0;
  logic        mem_rdy = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [3:0]  gnt, done, err;
  logic [7:0]  rd_data, mem_addr, mem_data;
  logic [1:0]  mem_mode;
  logic        busy, mem_start;

  simple_bus_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .req_mode(req_mode), .gnt(gnt), .done(done),
    .err(err), .rd_data(rd_data), .busy(busy), .mem_start(mem_start),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_mode(mem_mode),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: a transfer won at the end of cycle 0 shows gnt in cycle 1,
  // mem_start in cycle 2, waits from cycle 3, and completes one cycle after
  // the first mem_rdy seen in a wait cycle or after TO wait cycles.
  logic [3:0] e_gnt = '0, e_done = '0, e_err = '0;
  logic [7:0] e_rd = '0, e_addr = '0, e_data = '0;
  logic [1:0] e_mode = '0;
  logic       e_busy = 1'b0, e_start = 1'b0;
  bit act = 0, fin = 0;
  int off = 0, mwin = 0, mptr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt = '0; e_done = '0; e_err = '0; e_rd = '0; e_addr = '0;
      e_data = '0; e_mode = '0; e_busy = 1'b0; e_start = 1'b0;
      act = 0; fin = 0; off = 0; mwin = 0; mptr = 0;
    end else begin
      e_gnt = '0; e_done = '0; e_err = '0; e_start = 1'b0;
      if (!act) begin
        if (req != 4'b0) begin
          mwin   = pick(req, mptr);
          act    = 1; fin = 0; off = 1;
          e_addr = req_addr[8*mwin +: 8];
          e_data = req_data[8*mwin +: 8];
          e_mode = req_mode[2*mwin +: 2];
          e_gnt  = 4'(1) << mwin;
          e_busy = 1'b1;
        end
      end else if (fin) begin
        act = 0; fin = 0;
        mptr = (mwin + 1) % N;
        e_busy = 1'b0;
      end else begin
        if (off == 1) e_start = 1'b1;
        else if (off >= 3) begin
          if (mem_rdy) begin
            e_done = 4'(1) << mwin; e_rd = mem_rdata; fin = 1;
          end else if (off - 3 == TO - 1) begin
            e_done = 4'(1) << mwin; e_err = 4'(1) << mwin; e_rd = '0; fin = 1;
          end
        end
        off++;
      end
    end
  end

  int gq[$];
  int gnt_cyc = 0, start_cyc = 0, done_cyc = 0, start_cnt = 0, done_cnt = 0;
  logic [3:0] gnt_val = '0, done_val = '0, err_val = '0;
  logic [7:0] rd_at_done = '0;

  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_start", 32'(mem_start), 32'(e_start));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_data", 32'(mem_data), 32'(e_data));
    chk("mem_mode", 32'(mem_mode), 32'(e_mode));
    if (gnt != 4'b0) begin gq.push_back(oh2i(gnt)); gnt_cyc = cyc; gnt_val = gnt; end
    if (mem_start) begin start_cnt++; start_cyc = cyc; end
    if (done != 4'b0) begin
      done_cnt++; done_cyc = cyc; done_val = done; err_val = err; rd_at_done = rd_data;
    end
  end

  // Memory responder: rdy_at = wait cycle (1-based) carrying mem_rdy, 0 = never.
  int rdy_at = 1;
  logic [7:0] rdata_cfg = '0;
  bit stray = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_start === 1'b1) begin
        mem_rdy = stray; mem_rdata = stray ? 8'hEE : 8'h00;
        @(posedge clk); #1;
        if (rdy_at == 0) begin
          mem_rdy = 1'b0;
        end else begin
          for (int k = 1; k < rdy_at; k++) begin
            mem_rdy = 1'b0; @(posedge clk); #1;
          end
          mem_rdy = 1'b1; mem_rdata = rdata_cfg;
          @(posedge clk); #1;
          mem_rdy = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_grants(input int target, input string name);
    int b = 0;
    while (gq.size() < target && b < 100) begin tick(1); b++; end
    chk(name, 32'(gq.size() >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target, input string name);
    int b = 0;
    while (done_cnt < target && b < 100) begin tick(1); b++; end
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] d, input logic [1:0] m);
    req_addr[8*i +: 8] = a;
    req_data[8*i +: 8] = d;
    req_mode[2*i +: 2] = m;
  endtask

  int exp_ord[5] = '{0, 1, 2, 3, 0};
  int n0, d0, s0;

  initial begin
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mode", 32'(mem_mode), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick(2);

    // contention, best-case memory
    for (int i = 0; i < N; i++) set_slot(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 2'(i));
    rdy_at = 1; rdata_cfg = 8'h40;
    gq.delete(); s0 = start_cnt; d0 = done_cnt;
    req = 4'hF;
    wait_grants(5, "contention_grants_bound");
    req = 4'h0;
    wait_dones(d0 + 5, "contention_done_bound");
    tick(2);
    chk("contention_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < gq.size()) chk("contention_order", 32'(gq[i]), 32'(exp_ord[i]));
    chk("contention_starts", 32'(start_cnt - s0), 32'd5);
    chk("best_latency", 32'(done_cyc - gnt_cyc), 32'd3);

    // single requester, req dropped after winning
    set_slot(2, 8'hA5, 8'h5A, MODE_READ);
    rdy_at = 2; rdata_cfg = 8'h3C; d0 = done_cnt;
    req = 4'b0100; n0 = cyc;
    tick(1);
    req = 4'b0000;
    wait_dones(d0 + 1, "single_done_bound");
    tick(2);
    chk("single_gnt_cyc", 32'(gnt_cyc - n0), 32'd1);
    chk("single_gnt_val", 32'(gnt_val), 32'b0100);
    chk("single_start_cyc", 32'(start_cyc - n0), 32'd2);
    chk("single_done_cyc", 32'(done_cyc - n0), 32'd5);
    chk("single_done_val", 32'(done_val), 32'b0100);
    chk("single_err", 32'(err_val), 32'd0);
    chk("single_rd", 32'(rd_at_done), 32'h3C);
    chk("single_addr_hold", 32'(mem_addr), 32'hA5);
    chk("single_mode_hold", 32'(mem_mode), 32'(MODE_READ));

    // wrap: pointer now at 3
    set_slot(0, 8'h30, 8'h00, MODE_WRITE);
    set_slot(1, 8'h31, 8'h01, MODE_WRITE);
    rdy_at = 1; rdata_cfg = 8'h99; gq.delete(); d0 = done_cnt;
    req = 4'b0011;
    wait_grants(2, "wrap_grants_bound");
    req = 4'b0000;
    wait_dones(d0 + 2, "wrap_done_bound");
    tick(2);
    if (gq.size() >= 2) begin
      chk("wrap_first", 32'(gq[0]), 32'd0);
      chk("wrap_second", 32'(gq[1]), 32'd1);
    end

    // timeout with reserved mode
    set_slot(3, 8'hC3, 8'h3C, MODE_RSVD);
    rdy_at = 0; gq.delete(); d0 = done_cnt;
    req = 4'b1000;
    wait_grants(1, "timeout_grant_bound");
    req = 4'b0000;
    wait_dones(d0 + 1, "timeout_done_bound");
    tick(2);
    chk("timeout_cycles", 32'(done_cyc - (start_cyc + 1)), 32'd15);
    chk("timeout_done", 32'(done_val), 32'b1000);
    chk("timeout_err", 32'(err_val), 32'b1000);
    chk("timeout_rd", 32'(rd_at_done), 32'h00);
    chk("timeout_rsvd_mode", 32'(mem_mode), 32'd3);

    // stray mem_rdy coincident with mem_start
    set_slot(1, 8'h51, 8'h15, MODE_READ);
    stray = 1; rdy_at = 3; rdata_cfg = 8'h77; gq.delete(); d0 = done_cnt;
    req = 4'b0010;
    wait_grants(1, "stray_grant_bound");
    req = 4'b0000;
    wait_dones(d0 + 1, "stray_done_bound");
    stray = 0;
    tick(2);
    chk("stray_done_cyc", 32'(done_cyc - start_cyc), 32'd4);
    chk("stray_rd", 32'(rd_at_done), 32'h77);
    chk("stray_err", 32'(err_val), 32'd0);

    // reset during WAIT
    rdy_at = 0; s0 = start_cnt;
    req = 4'b1010;
    begin
      int b = 0;
      while (start_cnt == s0 && b < 50) begin tick(1); b++; end
      chk("rstmid_start_bound", 32'(start_cnt > s0), 32'd1);
    end
    tick(2);
    d0 = done_cnt;
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_rd", 32'(rd_data), 32'd0);
    chk("rstmid_addr", 32'(mem_addr), 32'd0);
    chk("rstmid_data", 32'(mem_data), 32'd0);
    chk("rstmid_mode", 32'(mem_mode), 32'd0);
    rdy_at = 1;
    tick(2);
    chk("rstmid_no_done", 32'(done_cnt), 32'(d0));
    gq.delete();
    #3 rst_n = 1'b1;
    wait_grants(1, "rstmid_grant_bound");
    req = 4'b0000;
    if (gq.size() >= 1) chk("rstmid_first_grant", 32'(gq[0]), 32'd1);
    wait_dones(d0 + 1, "rstmid_done_bound");
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
